// File: rtl/fb_video_pkg.sv
// Shared raster defaults, widths, pixel types and test-bar colours for the frame-buffer video reader.
package fb_video_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int ADDR_W = 19;
    localparam int HCNT_W = 10;
    localparam int VCNT_W = 10;

    typedef logic [23:0] rgb24_t;

    // Side-band flags that travel alongside a pixel; hs/vs already carry line polarity.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } vid_ctl_t;

    localparam rgb24_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb24_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb24_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb24_t BAR_GREEN   = 24'h00FF00;
    localparam rgb24_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb24_t BAR_RED     = 24'hFF0000;
    localparam rgb24_t BAR_BLUE    = 24'h0000FF;
    localparam rgb24_t BAR_BLACK   = 24'h000000;

    function automatic rgb24_t bar_color(input logic [2:0] idx);
        rgb24_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fb_video_reader_if.sv
// Frame RAM read port plus video output bundle; master is the reader, slave is RAM/encoder side.
interface fb_video_reader_if;
    import fb_video_pkg::*;

    logic [ADDR_W-1:0] ordaddr;
    logic              ord_en;
    rgb24_t            ordata;
    rgb24_t            orgb;
    logic              ode;
    logic              ohsync;
    logic              ovsync;
    logic              oframe_start;

    modport master (
        output ordaddr, ord_en, orgb, ode, ohsync, ovsync, oframe_start,
        input  ordata
    );

    modport slave (
        input  ordaddr, ord_en, orgb, ode, ohsync, ovsync, oframe_start,
        output ordata
    );

endinterface

// File: rtl/video_timing_gen.sv
// Raster counters with run-enable hold at the frame origin; h_cnt_o exists only with FB_TEST_PATTERN_EN.
module video_timing_gen
    import fb_video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
`ifdef FB_TEST_PATTERN_EN
    output logic [HCNT_W-1:0] h_cnt_o,
`endif
    output logic              active_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              fstart_o,
    output logic              wrap_o
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(HT - 1);
    localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_BEG = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(VT - 1);
    localparam logic [VCNT_W-1:0] V_ACT  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] VS_BEG = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCNT_W-1:0] h_q, h_d;
    logic [VCNT_W-1:0] v_q, v_d;
    logic              h_last, v_last;

    always_comb begin
        h_last = (h_q == H_LAST);
        v_last = (v_q == V_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (!en_i) begin
            // A dropped enable abandons the frame; restart is always from the origin.
            h_d = '0;
            v_d = '0;
        end else if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign active_o = en_i && (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_o  = en_i && (h_q >= HS_BEG) && (h_q < HS_END);
    assign vsync_o  = en_i && (v_q >= VS_BEG) && (v_q < VS_END);
    assign fstart_o = active_o && (h_q == '0) && (v_q == '0);
    assign wrap_o   = en_i && h_last && v_last;

`ifdef FB_TEST_PATTERN_EN
    assign h_cnt_o = h_q;
`endif

endmodule

// File: rtl/fb_video_reader.sv
// Frame-buffer scan-out: linear RAM reads, sync/de delay line aligned to read data, output register.
// Optional colour-bar generator is built when FB_TEST_PATTERN_EN is defined (adds the itest port).
module fb_video_reader
    import fb_video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int RD_LAT   = 1
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             ienable,
`ifdef FB_TEST_PATTERN_EN
    input  logic             itest,
`endif
    fb_video_reader_if.master vid
);

    localparam vid_ctl_t CTL_IDLE = '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, fs: 1'b0};

    logic tg_active, tg_hs, tg_vs, tg_fs, tg_wrap;
`ifdef FB_TEST_PATTERN_EN
    logic [HCNT_W-1:0] tg_h;
`endif

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i    (iclk),
        .rst_i    (ireset),
        .en_i     (ienable),
`ifdef FB_TEST_PATTERN_EN
        .h_cnt_o  (tg_h),
`endif
        .active_o (tg_active),
        .hsync_o  (tg_hs),
        .vsync_o  (tg_vs),
        .fstart_o (tg_fs),
        .wrap_o   (tg_wrap)
    );

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rdaddr_q;
    vid_ctl_t          ctl_a, ctl_b_q;
    vid_ctl_t          vld_pipe_q [RD_LAT:0];
    rgb24_t            orgb_q, orgb_d;

    // Address tracks the current pixel; it parks after the last active pixel until the frame wraps.
    always_comb begin
        addr_d = addr_q;
        if (!ienable || tg_wrap) begin
            addr_d = '0;
        end else if (tg_active) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_comb begin
        ctl_a    = CTL_IDLE;
        ctl_a.de = tg_active;
        ctl_a.hs = tg_hs ? SYNC_POL : ~SYNC_POL;
        ctl_a.vs = tg_vs ? SYNC_POL : ~SYNC_POL;
        ctl_a.fs = tg_fs;
    end

`ifdef FB_TEST_PATTERN_EN
    logic [HCNT_W-1:0] h_b_q;
    logic [HCNT_W-1:0] h_pipe_q [RD_LAT-1:0];

    // Column only matters while de is set, so this path carries no reset.
    always_ff @(posedge iclk) begin
        h_b_q       <= tg_h;
        h_pipe_q[0] <= h_b_q;
        for (int i = 1; i < RD_LAT; i++) begin
            h_pipe_q[i] <= h_pipe_q[i-1];
        end
    end
`endif

    // Stage RD_LAT-1 of the delay line lines up with the cycle ordata is valid.
    always_comb begin
        orgb_d = '0;
        if (vld_pipe_q[RD_LAT-1].de) begin
            orgb_d = vid.ordata;
`ifdef FB_TEST_PATTERN_EN
            if (itest) begin
                orgb_d = bar_color(3'(h_pipe_q[RD_LAT-1] / HCNT_W'(H_ACTIVE / 8)));
            end
`endif
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            addr_q   <= '0;
            rdaddr_q <= '0;
            ctl_b_q  <= CTL_IDLE;
            orgb_q   <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                vld_pipe_q[i] <= CTL_IDLE;
            end
        end else begin
            addr_q        <= addr_d;
            rdaddr_q      <= addr_q;
            ctl_b_q       <= ctl_a;
            vld_pipe_q[0] <= ctl_b_q;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
            orgb_q        <= orgb_d;
        end
    end

    assign vid.ordaddr      = rdaddr_q;
    assign vid.ord_en       = ctl_b_q.de;
    assign vid.orgb         = orgb_q;
    assign vid.ode          = vld_pipe_q[RD_LAT].de;
    assign vid.ohsync       = vld_pipe_q[RD_LAT].hs;
    assign vid.ovsync       = vld_pipe_q[RD_LAT].vs;
    assign vid.oframe_start = vld_pipe_q[RD_LAT].fs;

endmodule

// File: tb/tb_fb_video_reader.sv
// Bench for fb_video_reader on a shrunken raster: fixed vectors, hand sequences, random run vs a raster model.
`timescale 1ns/1ps
module tb_fb_video_reader;
    import fb_video_pkg::*;

    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 3;
    localparam int VA  = 6;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int FT  = HT * VT;
    localparam int LAT = 1;
    localparam bit POL = 1'b0;
    localparam int NV  = 18;

    logic iclk    = 1'b0;
    logic ireset  = 1'b1;
    logic ienable = 1'b0;
    logic tst     = 1'b0;

    fb_video_reader_if vid ();

    fb_video_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL), .RD_LAT (LAT)
    ) dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .ienable (ienable),
`ifdef FB_TEST_PATTERN_EN
        .itest   (tst),
`endif
        .vid     (vid)
    );

    always #5 iclk = ~iclk;

    // RAM returns {5'b0, addr} for real reads and junk otherwise.
    rgb24_t ram_q [LAT];
    always @(posedge iclk) begin
        ram_q[0] <= vid.ord_en ? {5'b0, vid.ordaddr} : rgb24_t'($urandom);
        for (int i = 1; i < LAT; i++) ram_q[i] <= ram_q[i-1];
    end
    assign vid.ordata = ram_q[LAT-1];

    typedef struct packed {
        logic              de;
        logic              hs;
        logic              vs;
        logic              fs;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       h;
    } exp_t;

    typedef struct {
        int     k;
        logic   de;
        logic   hs;
        logic   vs;
        logic   fs;
        rgb24_t rgb;
    } vec_t;

    exp_t   hist [LAT+2];
    vec_t   tbl  [NV];
    rgb24_t exp_rgb;
    int     n, total, bad, cyc_n;

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.hs = ~POL;
        e.vs = ~POL;
        return e;
    endfunction

    // Pixel position -> raster coordinates -> expected stage-A view.
    function automatic exp_t stage_a(int pos, bit en);
        exp_t e;
        int h, v;
        h = pos % HT;
        v = pos / HT;
        e.de   = en && (h < HA) && (v < VA);
        e.hs   = (en && h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
        e.vs   = (en && v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
        e.fs   = e.de && (pos == 0);
        e.addr = ADDR_W'(v * HA + h);
        e.h    = 32'(h);
        return e;
    endfunction

    function automatic rgb24_t bar(logic [31:0] h);
        rgb24_t c;
        case (h / (HA / 8))
            0:       c = 24'hFFFFFF;
            1:       c = 24'hFFFF00;
            2:       c = 24'h00FFFF;
            3:       c = 24'h00FF00;
            4:       c = 24'hFF00FF;
            5:       c = 24'hFF0000;
            6:       c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare everything half a cycle later.
    task automatic cyc(input bit rst, input bit en);
        ireset  = rst;
        ienable = en;
        @(posedge iclk);
        if (rst) begin
            for (int i = 0; i < LAT + 2; i++) hist[i] = idle_e();
            n = 0;
            exp_rgb = '0;
        end else begin
            for (int i = LAT + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = stage_a(n, en);
            n = en ? (n + 1) % FT : 0;
            exp_rgb = !hist[LAT+1].de ? 24'h0 :
                      tst ? bar(hist[LAT+1].h) : {5'b0, hist[LAT+1].addr};
        end
        @(negedge iclk);
        cyc_n++;
        chk("outs",
            64'({vid.orgb, vid.ode, vid.ohsync, vid.ovsync, vid.oframe_start, vid.ord_en}),
            64'({exp_rgb, hist[LAT+1].de, hist[LAT+1].hs, hist[LAT+1].vs, hist[LAT+1].fs, hist[0].de}));
        if (hist[0].de) chk("rdaddr", 64'(vid.ordaddr), 64'(hist[0].addr));
    endtask

    initial begin
        int ti, de_cnt, vs_cnt, fs_cnt;
        bit en_r;
        total = 0; bad = 0; n = 0; cyc_n = 0;
        for (int i = 0; i < LAT + 2; i++) hist[i] = idle_e();

        // {k after release, de, hs, vs, fs, rgb}; raster 24x10, output lags counters by 3.
        tbl[0]  = '{1,   1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
        tbl[1]  = '{2,   1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
        tbl[2]  = '{3,   1'b1, 1'b1, 1'b1, 1'b1, 24'd0};
        tbl[3]  = '{4,   1'b1, 1'b1, 1'b1, 1'b0, 24'd1};
        tbl[4]  = '{18,  1'b1, 1'b1, 1'b1, 1'b0, 24'd15};
        tbl[5]  = '{19,  1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
        tbl[6]  = '{20,  1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
        tbl[7]  = '{21,  1'b0, 1'b0, 1'b1, 1'b0, 24'd0};
        tbl[8]  = '{23,  1'b0, 1'b0, 1'b1, 1'b0, 24'd0};
        tbl[9]  = '{24,  1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
        tbl[10] = '{27,  1'b1, 1'b1, 1'b1, 1'b0, 24'd16};
        tbl[11] = '{138, 1'b1, 1'b1, 1'b1, 1'b0, 24'd95};
        tbl[12] = '{139, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
        tbl[13] = '{171, 1'b0, 1'b1, 1'b0, 1'b0, 24'd0};
        tbl[14] = '{218, 1'b0, 1'b1, 1'b0, 1'b0, 24'd0};
        tbl[15] = '{219, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
        tbl[16] = '{243, 1'b1, 1'b1, 1'b1, 1'b1, 24'd0};
        tbl[17] = '{244, 1'b1, 1'b1, 1'b1, 1'b0, 24'd1};

        repeat (3) cyc(1'b1, 1'b0);
        chk("rst_idle",
            64'({vid.ode, vid.ohsync, vid.ovsync, vid.oframe_start, vid.ord_en, vid.orgb, vid.ordaddr}),
            64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 19'h0}));

        ti = 0; de_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int k = 1; k <= 250; k++) begin
            cyc(1'b0, 1'b1);
            if (k >= 3 && k < 3 + FT) begin
                de_cnt += int'(vid.ode);
                vs_cnt += int'(vid.ovsync == POL);
                fs_cnt += int'(vid.oframe_start);
            end
            if (ti < NV && tbl[ti].k == k) begin
                chk($sformatf("vec%0d", ti),
                    64'({vid.ode, vid.ohsync, vid.ovsync, vid.oframe_start, vid.orgb}),
                    64'({tbl[ti].de, tbl[ti].hs, tbl[ti].vs, tbl[ti].fs, tbl[ti].rgb}));
                ti++;
            end
        end
        chk("vec_all_hit", 64'(ti), 64'(NV));
        chk("de_per_frame", 64'(de_cnt), 64'(HA * VA));
        chk("vsync_len", 64'(vs_cnt), 64'(VS * HT));
        chk("fs_per_frame", 64'(fs_cnt), 64'd1);

        // Enable drop at line 2, h=10, then restart.
        for (int i = 0; i < FT && n != 2 * HT + 10; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("drop_rden", 64'(vid.ord_en), 64'd0);
        repeat (2) cyc(1'b0, 1'b0);
        chk("drop_de", 64'(vid.ode), 64'd0);
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("re_addr", 64'({vid.ord_en, vid.ordaddr}), 64'({1'b1, 19'h0}));
        repeat (2) cyc(1'b0, 1'b1);
        chk("re_fs", 64'({vid.ode, vid.oframe_start, vid.orgb}), 64'({1'b1, 1'b1, 24'h0}));

        // Reset in the middle of an active line.
        repeat (37) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("midrst",
            64'({vid.ode, vid.ohsync, vid.ovsync, vid.oframe_start, vid.ord_en, vid.orgb, vid.ordaddr}),
            64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 19'h0}));
        repeat (3) cyc(1'b0, 1'b1);
        chk("rst_restart", 64'({vid.ode, vid.oframe_start, vid.orgb}), 64'({1'b1, 1'b1, 24'h0}));

`ifdef FB_TEST_PATTERN_EN
        tst = 1'b1;
        cyc(1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 1'b1);
            if (k == 3)  chk("bar_px0",  64'(vid.orgb), 64'h00FFFFFF);
            if (k == 5)  chk("bar_px2",  64'(vid.orgb), 64'h00FFFF00);
            if (k == 18) chk("bar_px15", 64'(vid.orgb), 64'h00000000);
        end
        tst = 1'b0;
`endif

        // Random enable drops, resets (and pattern toggles) against the model.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (en_r && $urandom_range(0, 149) == 0) en_r = 1'b0;
            else if (!en_r && $urandom_range(0, 9) == 0) en_r = 1'b1;
`ifdef FB_TEST_PATTERN_EN
            if ($urandom_range(0, 99) == 0) tst = ~tst;
`endif
            cyc($urandom_range(0, 799) == 0, en_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
